// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome stage over GF(16), x^4+x+1.
// Horner evaluation of S1..S6, one received symbol per clock.
module rs_syndrome_calc #(
    parameter int N    = 15,
    parameter int NSYM = 6,
    parameter int SW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*SW-1:0]      recievedWordIn,
    output logic                 busy,
    output logic                 done,
    output logic [NSYM*SW-1:0]   syndromesOut,
    output logic                 errorDetected
);

    typedef enum logic [0:0] {IDLE, CALC} state_t;

    state_t              r_state;
    logic [N*SW-1:0]     r_word;
    logic [3:0]          r_idx;
    logic [SW-1:0]       r_acc [NSYM];

    logic [SW-1:0]       w_sym;
    logic [SW-1:0]       w_acc_next [NSYM];
    logic [NSYM*SW-1:0]  w_syn_next;

    function automatic logic [3:0] mul_alpha(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] mul_alpha_n(input logic [3:0] a,
                                               input int n);
        logic [3:0] t;
        t = a;
        for (int k = 0; k < n; k++) t = mul_alpha(t);
        return t;
    endfunction

    assign w_sym = r_word[r_idx*SW +: SW];

    always_comb begin
        w_syn_next = '0;
        for (int j = 0; j < NSYM; j++) begin
            w_acc_next[j] = mul_alpha_n(r_acc[j], j + 1) ^ w_sym;
            w_syn_next[j*SW +: SW] = w_acc_next[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_word        <= '0;
            r_idx         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            syndromesOut  <= '0;
            errorDetected <= 1'b0;
            for (int j = 0; j < NSYM; j++) r_acc[j] <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_word  <= recievedWordIn;
                        r_idx   <= 4'(N - 1);
                        busy    <= 1'b1;
                        r_state <= CALC;
                        for (int j = 0; j < NSYM; j++) r_acc[j] <= '0;
                    end
                end
                CALC: begin
                    for (int j = 0; j < NSYM; j++) r_acc[j] <= w_acc_next[j];
                    // Last symbol: publish straight from the next-state values.
                    if (r_idx == 4'd0) begin
                        r_state       <= IDLE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        syndromesOut  <= w_syn_next;
                        errorDetected <= |w_syn_next;
                    end else begin
                        r_idx <= r_idx - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Randomized self-checking bench for rs_syndrome_calc.
// Reference: direct polynomial evaluation with GF(16) log/antilog tables.
module tb_rs_syndrome_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [59:0] recievedWordIn;
    logic        busy;
    logic        done;
    logic [23:0] syndromesOut;
    logic        errorDetected;

    int n_tests = 0;
    int n_fail  = 0;
    int gexp [15];
    int glog [16];
    logic [23:0] prev_syn;

    rs_syndrome_calc dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .recievedWordIn(recievedWordIn),
        .busy          (busy),
        .done          (done),
        .syndromesOut  (syndromesOut),
        .errorDetected (errorDetected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // S_j = sum_i r_i * alpha^(i*j)
    function automatic logic [23:0] syn_model(input logic [59:0] w);
        logic [23:0] s;
        logic [3:0]  sj;
        int          r;
        s = '0;
        for (int j = 1; j <= 6; j++) begin
            sj = 4'h0;
            for (int i = 0; i < 15; i++) begin
                r = int'(w[4*i +: 4]);
                if (r != 0) sj ^= 4'(gexp[(glog[r] + i*j) % 15]);
            end
            s[4*(j-1) +: 4] = sj;
        end
        return s;
    endfunction

    // Codeword = m(x) * g(x), g(x) = prod (x + alpha^j), j = 1..6
    function automatic logic [59:0] make_codeword();
        int g [7];
        int m [9];
        int c;
        logic [59:0] w;
        for (int k = 0; k < 7; k++) g[k] = 0;
        g[0] = 1;
        for (int j = 1; j <= 6; j++)
            for (int k = 6; k >= 0; k--)
                g[k] = (k > 0 ? g[k-1] : 0) ^ gmul(g[k], gexp[j]);
        for (int k = 0; k < 9; k++) m[k] = int'($urandom_range(0, 15));
        w = '0;
        for (int i = 0; i < 15; i++) begin
            c = 0;
            for (int k = 0; k < 9; k++)
                if (i - k >= 0 && i - k <= 6) c ^= gmul(m[k], g[i-k]);
            w[4*i +: 4] = 4'(c);
        end
        return w;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 7) chk("hold", 64'(syndromesOut), 64'(prev_syn));
        end while (!done && cyc < 40);
    endtask

    task automatic finish_checks(input string tag, input logic [59:0] w);
        logic [23:0] e;
        e = syn_model(w);
        chk({tag, "_syn"}, 64'(syndromesOut), 64'(e));
        chk({tag, "_err"}, 64'(errorDetected), 64'(|e));
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
        prev_syn = e;
    endtask

    task automatic run_word(input string tag, input logic [59:0] w);
        int c;
        recievedWordIn = w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        recievedWordIn = ~w;
        chk({tag, "_busy1"}, 64'(busy), 64'd1);
        wait_done(c);
        chk({tag, "_lat"}, 64'(c), 64'd15);
        finish_checks(tag, w);
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [59:0] w, w2, cw, ev;
        int c, v, pulses;

        v = 1;
        for (int k = 0; k < 15; k++) begin
            gexp[k] = v;
            glog[v] = k;
            v = v << 1;
            if (v >= 16) v ^= 19;
        end
        glog[0] = 0;

        rst = 1'b1;
        start = 1'b0;
        recievedWordIn = '0;
        prev_syn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_syn", 64'(syndromesOut), 64'd0);
        chk("rst_err", 64'(errorDetected), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_word("zero", 60'h0);
        chk("zero_const", 64'(syndromesOut), 64'h000000);
        run_word("sym0", 60'h1);
        chk("sym0_const", 64'(syndromesOut), 64'h111111);
        run_word("sym3", 60'h3 << 12);
        chk("sym3_const", 64'(syndromesOut), 64'hB32D7B);
        run_word("sym14", 60'h1 << 56);
        chk("sym14_const", 64'(syndromesOut), 64'hA7EFD9);

        for (int t = 0; t < 20; t++) begin
            w = {$urandom, $urandom};
            run_word("rand", w);
        end

        ev = '0;
        ev[12 +: 4] = 4'b0011;
        ev[24 +: 4] = 4'b0101;
        ev[28 +: 4] = 4'b0001;
        ev[44 +: 4] = 4'b1010;
        for (int t = 0; t < 5; t++) begin
            cw = make_codeword();
            run_word("cw", cw);
            chk("cw_zero", 64'(syndromesOut), 64'd0);
            run_word("cw_err", cw ^ ev);
            chk("cw_err_ev", 64'(syndromesOut), 64'(syn_model(ev)));
            chk("cw_err_flag", 64'(errorDetected), 64'd1);
        end

        // start pulsed mid-computation is ignored
        w = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        recievedWordIn = w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
            if (c == 5) begin start = 1'b1; recievedWordIn = w2; end
            if (c == 6) start = 1'b0;
        end while (!done && c < 40);
        chk("midstart_lat", 64'(c), 64'd15);
        finish_checks("midstart", w);
        @(posedge clk); #1;
        chk("midstart_idle", 64'(busy), 64'd0);

        // async reset mid-computation
        recievedWordIn = 60'h1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_syn", 64'(syndromesOut), 64'd0);
        chk("arst_err", 64'(errorDetected), 64'd0);
        @(posedge clk); #3 rst = 1'b0;
        prev_syn = '0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("arst_nodone", 64'(pulses), 64'd0);
        w = {$urandom, $urandom};
        run_word("post_rst", w);

        // start held high: back-to-back runs every 16 cycles
        w = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        recievedWordIn = w;
        start = 1'b1;
        @(posedge clk); #1;
        wait_done(c);
        chk("b2b_lat1", 64'(c), 64'd15);
        finish_checks("b2b_a", w);
        recievedWordIn = w2;
        wait_done(c);
        start = 1'b0;
        chk("b2b_lat2", 64'(c), 64'd16);
        finish_checks("b2b_b", w2);
        @(posedge clk); #1;
        chk("b2b_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
